// File: rtl/echo_detector.sv
// rtl/echo_detector.sv - echo qualifier with blanking, run qualification and hold-off
// Optional adaptive noise floor: define ECHO_DET_NOISE_FLOOR_EN.
module echo_detector #(
    parameter int DATA_WIDTH     = 16,
    parameter int TIME_WIDTH     = 16,
    parameter int THRESHOLD      = 1000,
    parameter int BLANK_CYCLES   = 200,
    parameter int QUAL_COUNT     = 4,
    parameter int HOLDOFF_CYCLES = 1000
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         burst_start_in,
    input  logic signed [DATA_WIDTH-1:0] sample_in,
    input  logic                         sample_valid_in,
    input  logic [TIME_WIDTH-1:0]        time_since_emission_in,
    output logic                         echo_detected_out,
    output logic [TIME_WIDTH-1:0]        echo_time_out,
    output logic [DATA_WIDTH-2:0]        echo_peak_out,
    output logic [7:0]                   echo_count_out,
    output logic                         armed_out,
    output logic [DATA_WIDTH-2:0]        noise_floor_out
);

    localparam int              MW         = DATA_WIDTH - 1;
    localparam logic [MW-1:0]   MAG_MAX    = {MW{1'b1}};
    localparam logic [MW-1:0]   THR_BASE   = MW'(THRESHOLD);
    localparam logic [31:0]     BLANK_LAST = (BLANK_CYCLES > 0) ? 32'(BLANK_CYCLES - 1) : 32'd0;
    localparam logic [31:0]     HOLD_LAST  = 32'(HOLDOFF_CYCLES);
    localparam logic [7:0]      QC         = 8'(QUAL_COUNT);

    typedef enum logic [2:0] {IDLE, BLANK, ARMED, QUALIFY, HOLDOFF} state_t;

    state_t                state, state_nxt;
    logic [31:0]           cnt, cnt_nxt;
    logic [7:0]            run, run_nxt, run_inc;
    logic [MW-1:0]         peak, peak_nxt;
    logic [TIME_WIDTH-1:0] ptime, ptime_nxt;
    logic [MW-1:0]         mag, thr;
    logic [DATA_WIDTH-1:0] neg;
    logic                  qual, fire;

    // Absolute value; the most negative code has no positive twin and saturates.
    always_comb begin
        neg = ~sample_in + 1'b1;
        if (!sample_in[DATA_WIDTH-1])
            mag = sample_in[MW-1:0];
        else if (sample_in[MW-1:0] == '0)
            mag = MAG_MAX;
        else
            mag = neg[MW-1:0];
    end

`ifdef ECHO_DET_NOISE_FLOOR_EN
    logic [MW-1:0]        floor_q;
    logic [MW:0]          thr_sum, floor_new;
    logic signed [MW:0]   floor_diff, floor_step;
    logic                 floor_upd;

    always_comb begin
        thr_sum    = {1'b0, THR_BASE} + {1'b0, floor_q};
        thr        = thr_sum[MW] ? MAG_MAX : thr_sum[MW-1:0];
        floor_diff = $signed({1'b0, mag}) - $signed({1'b0, floor_q});
        floor_step = floor_diff >>> 4;
        floor_new  = {1'b0, floor_q} + $unsigned(floor_step);
    end

    // Only quiet samples seen while armed train the floor; bursts leave it alone.
    assign floor_upd = (state == ARMED) && sample_valid_in && !qual && !burst_start_in;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            floor_q <= '0;
        else if (floor_upd)
            floor_q <= floor_new[MW-1:0];
    end

    assign noise_floor_out = floor_q;
`else
    assign thr             = THR_BASE;
    assign noise_floor_out = '0;
`endif

    assign qual    = sample_valid_in && (mag > thr);
    assign run_inc = run + 8'd1;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        run_nxt   = run;
        peak_nxt  = peak;
        ptime_nxt = ptime;
        fire      = 1'b0;
        if (burst_start_in) begin
            state_nxt = (BLANK_CYCLES > 0) ? BLANK : ARMED;
            cnt_nxt   = '0;
            run_nxt   = '0;
        end else begin
            case (state)
                IDLE: ;
                BLANK: begin
                    if (cnt == BLANK_LAST) state_nxt = ARMED;
                    else                   cnt_nxt   = cnt + 32'd1;
                end
                ARMED: begin
                    if (qual) begin
                        ptime_nxt = time_since_emission_in;
                        peak_nxt  = mag;
                        run_nxt   = 8'd1;
                        if (QC == 8'd1) fire      = 1'b1;
                        else            state_nxt = QUALIFY;
                    end
                end
                QUALIFY: begin
                    if (qual) begin
                        run_nxt = run_inc;
                        if (mag > peak) peak_nxt = mag;
                        if (run_inc == QC) fire = 1'b1;
                    end else if (sample_valid_in) begin
                        state_nxt = ARMED;
                        run_nxt   = '0;
                    end
                end
                HOLDOFF: begin
                    // Counter runs 0..HOLDOFF_CYCLES, so re-arm lands HOLDOFF_CYCLES+1 edges after detection.
                    if (cnt == HOLD_LAST) state_nxt = ARMED;
                    else                  cnt_nxt   = cnt + 32'd1;
                end
                default: state_nxt = IDLE;
            endcase
        end
        if (fire) begin
            state_nxt = (HOLDOFF_CYCLES > 0) ? HOLDOFF : ARMED;
            cnt_nxt   = '0;
            run_nxt   = '0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state             <= IDLE;
            cnt               <= '0;
            run               <= '0;
            peak              <= '0;
            ptime             <= '0;
            echo_detected_out <= 1'b0;
            echo_time_out     <= '0;
            echo_peak_out     <= '0;
            echo_count_out    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            run   <= run_nxt;
            peak  <= peak_nxt;
            ptime <= ptime_nxt;
            if (burst_start_in) begin
                echo_detected_out <= 1'b0;
                echo_time_out     <= '0;
                echo_peak_out     <= '0;
                echo_count_out    <= '0;
            end else if (fire) begin
                echo_detected_out <= 1'b1;
                echo_time_out     <= ptime_nxt;
                echo_peak_out     <= peak_nxt;
                if (echo_count_out != 8'hFF)
                    echo_count_out <= echo_count_out + 8'd1;
            end else begin
                echo_detected_out <= 1'b0;
            end
        end
    end

    assign armed_out = (state == ARMED) || (state == QUALIFY);

endmodule

// File: tb/tb_echo_detector.sv
// tb/tb_echo_detector.sv - randomized and directed bench for echo_detector against a timeline model
module tb_echo_detector;

    localparam int THR = 1000;
    localparam int B   = 200;
    localparam int QC  = 4;
    localparam int H   = 1000;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        burst_start_in = 1'b0;
    logic [15:0] sample_in = '0;
    logic        sample_valid_in = 1'b0;
    logic [15:0] time_since_emission_in = '0;
    logic        echo_detected_out;
    logic [15:0] echo_time_out;
    logic [14:0] echo_peak_out;
    logic [7:0]  echo_count_out;
    logic        armed_out;
    logic [14:0] noise_floor_out;

    echo_detector dut (
        .clk_in                 (clk_in),
        .rst_in                 (rst_in),
        .burst_start_in         (burst_start_in),
        .sample_in              (sample_in),
        .sample_valid_in        (sample_valid_in),
        .time_since_emission_in (time_since_emission_in),
        .echo_detected_out      (echo_detected_out),
        .echo_time_out          (echo_time_out),
        .echo_peak_out          (echo_peak_out),
        .echo_count_out         (echo_count_out),
        .armed_out              (armed_out),
        .noise_floor_out        (noise_floor_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;
    int edge_n   = 0;
    logic [15:0] tcnt = '0;
    int pulses[$];
    int pcounts[$];

    // Model: samples are eligible from edge elig onwards while active.
    bit m_active = 0;
    int m_elig = 0, m_run = 0, m_ptime = 0, m_ppeak = 0, m_floor = 0;
    int m_det = 0, m_time = 0, m_peak = 0, m_count = 0, m_armed = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
    endtask

    function automatic int magnitude(input int s);
        int m;
        m = (s < 0) ? -s : s;
        return (m > 32767) ? 32767 : m;
    endfunction

    task automatic model_edge(input bit r, input bit b, input bit v, input int s, input int t);
        int m, thr;
        m_det = 0;
        if (r) begin
            m_active = 0; m_run = 0; m_floor = 0;
            m_time = 0; m_peak = 0; m_count = 0;
        end else if (b) begin
            m_active = 1; m_elig = edge_n + 1 + B; m_run = 0;
            m_time = 0; m_peak = 0; m_count = 0;
        end else if (m_active && edge_n >= m_elig && v) begin
            m = magnitude(s);
`ifdef ECHO_DET_NOISE_FLOOR_EN
            thr = THR + m_floor;
            if (thr > 32767) thr = 32767;
`else
            thr = THR;
`endif
            if (m > thr) begin
                if (m_run == 0) begin m_ptime = t; m_ppeak = m; end
                else if (m > m_ppeak) m_ppeak = m;
                m_run++;
                if (m_run == QC) begin
                    m_det = 1; m_time = m_ptime; m_peak = m_ppeak;
                    if (m_count < 255) m_count++;
                    m_run = 0;
                    m_elig = (H == 0) ? edge_n + 1 : edge_n + 2 + H;
                end
            end else begin
`ifdef ECHO_DET_NOISE_FLOOR_EN
                if (m_run == 0) m_floor = m_floor + ((m - m_floor) >>> 4);
`endif
                m_run = 0;
            end
        end
        m_armed = (m_active && (edge_n + 1 >= m_elig)) ? 1 : 0;
    endtask

    task automatic step(input bit r, input bit b, input bit v, input int s);
        rst_in = r;
        burst_start_in = b;
        sample_valid_in = v;
        sample_in = 16'(s);
        time_since_emission_in = tcnt;
        @(posedge clk_in);
        model_edge(r, b, v, s, int'(tcnt));
        tcnt = b ? 16'd1 : tcnt + 16'd1;
        @(negedge clk_in);
        check("det",   echo_detected_out, m_det);
        check("time",  echo_time_out, m_time);
        check("peak",  echo_peak_out, m_peak);
        check("count", echo_count_out, m_count);
        check("armed", armed_out, m_armed);
`ifdef ECHO_DET_NOISE_FLOOR_EN
        check("floor", noise_floor_out, m_floor);
`else
        check("floor", noise_floor_out, 0);
`endif
        if (echo_detected_out) begin
            pulses.push_back(edge_n);
            pcounts.push_back(int'(echo_count_out));
        end
        edge_n++;
    endtask

    initial begin
        int base, seg, lvl, idx;
        int levels[9] = '{0, 500, 1000, 1001, 2000, -1500, -32768, 32767, 3000};

        @(negedge clk_in);
        step(1, 0, 0, 0);
        step(1, 0, 1, 5000);
        check("rst_det", echo_detected_out, 0);
        check("rst_count", echo_count_out, 0);
        check("rst_armed", armed_out, 0);
        step(0, 0, 1, 5000);

        // Default scenario: constant 2000 after a burst
        pulses.delete(); pcounts.delete();
        base = edge_n;
        step(0, 1, 1, 2000);
        for (int k = 1; k <= 210; k++) step(0, 0, 1, 2000);
        check("def_npulse", pulses.size(), 1);
        check("def_pulse_edge", (pulses.size() > 0) ? pulses[0] - base : -1, 204);
        check("def_time", echo_time_out, 201);
        check("def_peak", echo_peak_out, 2000);
        check("def_count", echo_count_out, 1);

        // Spike rejection
        pulses.delete();
        step(0, 1, 0, 0);
        for (int k = 1; k <= 200; k++) step(0, 0, 1, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 1, 2000);
        step(0, 0, 1, 500);
        for (int k = 0; k < 4; k++) step(0, 0, 1, 2000);
        for (int k = 0; k < 10; k++) step(0, 0, 1, 0);
        check("spike_npulse", pulses.size(), 1);
        check("spike_time", echo_time_out, 205);

        // Threshold is strict, most negative sample saturates
        pulses.delete();
        step(0, 1, 0, 0);
        for (int k = 1; k <= 200; k++) step(0, 0, 0, 0);
        for (int k = 0; k < 10; k++) step(0, 0, 1, 1000);
        check("thr_npulse", pulses.size(), 0);
        for (int k = 0; k < 4; k++) step(0, 0, 1, -32768);
        step(0, 0, 1, 0);
        check("sat_npulse", pulses.size(), 1);
        check("sat_peak", echo_peak_out, 32767);

        // Hold-off spacing and counting
        pulses.delete(); pcounts.delete();
        base = edge_n;
        step(0, 1, 1, 3000);
        for (int k = 1; k <= 2300; k++) step(0, 0, 1, 3000);
        check("hold_npulse", pulses.size(), 3);
        if (pulses.size() == 3) begin
            check("hold_p0", pulses[0] - base, 204);
            check("hold_gap1", pulses[1] - pulses[0], H + QC + 1);
            check("hold_gap2", pulses[2] - pulses[1], H + QC + 1);
            check("hold_c1", pcounts[0], 1);
            check("hold_c2", pcounts[1], 2);
            check("hold_c3", pcounts[2], 3);
        end
        step(0, 1, 0, 0);
        check("burst_clears_count", echo_count_out, 0);

        // Burst on the 4th qualifying sample wins
        pulses.delete();
        for (int k = 1; k <= 200; k++) step(0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 1, 3000);
        step(0, 1, 1, 3000);
        check("prio_det", echo_detected_out, 0);
        check("prio_armed", armed_out, 0);
        for (int k = 1; k <= 200; k++) step(0, 0, 0, 0);
        for (int k = 0; k < 2; k++) step(0, 0, 1, 3000);
        step(1, 0, 1, 3000);
        check("rst_mid_armed", armed_out, 0);
        check("rst_mid_count", echo_count_out, 0);
        for (int k = 0; k < 4; k++) step(0, 0, 1, 3000);
        check("rst_idle_npulse", pulses.size(), 0);

        // Randomized segments
        seg = 0; lvl = 0;
        for (int i = 0; i < 20000; i++) begin
            if (seg == 0) begin
                idx = int'($urandom_range(0, 9));
                lvl = (idx == 9) ? int'($urandom_range(0, 65535)) - 32768 : levels[idx];
                seg = int'($urandom_range(1, 12));
            end
            seg--;
            step($urandom_range(0, 1999) == 0, $urandom_range(0, 399) == 0,
                 $urandom_range(0, 9) != 0, lvl);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
